// File: rtl/mac_tx_pkg.sv
// Shared types, encodings and defaults for the half-duplex MAC transmit retry controller.
package mac_tx_pkg;

    localparam int unsigned IPG_CYCLES_DEF   = 12;
    localparam int unsigned JAM_CYCLES_DEF   = 4;
    localparam int unsigned SLOT_CYCLES_DEF  = 64;
    localparam int unsigned MAX_ATTEMPTS_DEF = 16;
    localparam int unsigned BO_EXP_CAP       = 9;

    localparam int unsigned ATT_W = 5;
    localparam int unsigned EXP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEFER,
        ST_TX,
        ST_JAM,
        ST_BO_START,
        ST_BO_WAIT,
        ST_ACK,
        ST_ABORT
    } tx_state_e;

    typedef enum logic [1:0] {
        ABORT_NONE   = 2'b00,
        ABORT_EXCESS = 2'b01,
        ABORT_LATE   = 2'b10
    } abort_reason_e;

    // Backoff exponent for the generator: attempts so far, capped.
    function automatic logic [EXP_W-1:0] bo_exponent(input logic [ATT_W-1:0] attempts);
        if (attempts > ATT_W'(BO_EXP_CAP)) begin
            return EXP_W'(BO_EXP_CAP);
        end
        return attempts[EXP_W-1:0];
    endfunction

endpackage

// File: rtl/tx_defer_timer.sv
// Inter-packet-gap timer: counts carrier-free clocks while enabled, flags the gap on the last one.
module tx_defer_timer
    import mac_tx_pkg::*;
#(
    parameter int unsigned IPG_CYCLES = IPG_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic carrier_sense,
    output logic gap_met
);

    localparam int unsigned CNT_W = $clog2(IPG_CYCLES + 1);

    logic [CNT_W-1:0] ipg_cnt_q;

    // Combinational so the start decision sees carrier on the same cycle.
    assign gap_met = enable && !carrier_sense && (ipg_cnt_q == CNT_W'(IPG_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !enable || carrier_sense) begin
            ipg_cnt_q <= '0;
        end else if (!gap_met) begin
            ipg_cnt_q <= ipg_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tx_retry_ctrl.sv
// CSMA/CD transmit sequencer: defer, transmit, jam, backoff, ack or abort.
// Optional statistics counters are built when TX_STATS_EN is defined.
module tx_retry_ctrl
    import mac_tx_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS = MAX_ATTEMPTS_DEF,
    parameter int unsigned IPG_CYCLES   = IPG_CYCLES_DEF,
    parameter int unsigned JAM_CYCLES   = JAM_CYCLES_DEF,
    parameter int unsigned SLOT_CYCLES  = SLOT_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tx_req,
    input  logic             carrier_sense,
    input  logic             collision,
    input  logic             tx_done,
    output logic             tx_start,
    output logic             tx_stop,
    output logic             jam_en,
    output logic             backoff_init,
    output logic [EXP_W-1:0] retry_count,
    input  logic             backoff_done,
    output logic             tx_ack,
    output logic             tx_abort,
`ifdef TX_STATS_EN
    output logic [15:0]      col_total,
    output logic [15:0]      excess_cnt,
    output logic [15:0]      late_cnt,
`endif
    output logic [1:0]       abort_reason
);

    localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES + 1);
    localparam int unsigned JAM_W  = $clog2(JAM_CYCLES + 1);

    tx_state_e          state_q;
    logic [ATT_W-1:0]   attempts_q;
    logic [SLOT_W-1:0]  slot_cnt_q;
    logic [JAM_W-1:0]   jam_cnt_q;
    logic               late_q;
    logic               gap_met;
    logic [ATT_W-1:0]   attempts_d;

    assign attempts_d = attempts_q + ATT_W'(1);

    tx_defer_timer #(
        .IPG_CYCLES (IPG_CYCLES)
    ) u_defer (
        .clock         (clock),
        .reset         (reset),
        .enable        (state_q == ST_DEFER),
        .carrier_sense (carrier_sense),
        .gap_met       (gap_met)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            attempts_q   <= '0;
            slot_cnt_q   <= '0;
            jam_cnt_q    <= '0;
            late_q       <= 1'b0;
            tx_start     <= 1'b0;
            tx_stop      <= 1'b0;
            jam_en       <= 1'b0;
            backoff_init <= 1'b0;
            retry_count  <= '0;
            tx_ack       <= 1'b0;
            tx_abort     <= 1'b0;
            abort_reason <= ABORT_NONE;
        end else begin
            // Pulse outputs default low; each state raises what it needs for one cycle.
            tx_start     <= 1'b0;
            tx_stop      <= 1'b0;
            backoff_init <= 1'b0;
            tx_ack       <= 1'b0;
            tx_abort     <= 1'b0;
            abort_reason <= ABORT_NONE;

            case (state_q)
                ST_IDLE: begin
                    if (tx_req) begin
                        attempts_q <= '0;
                        state_q    <= ST_DEFER;
                    end
                end

                ST_DEFER: begin
                    if (gap_met) begin
                        tx_start   <= 1'b1;
                        slot_cnt_q <= '0;
                        state_q    <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (slot_cnt_q < SLOT_W'(SLOT_CYCLES)) begin
                        slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
                    end
                    if (collision) begin
                        tx_stop   <= 1'b1;
                        jam_en    <= 1'b1;
                        jam_cnt_q <= '0;
                        late_q    <= (slot_cnt_q >= SLOT_W'(SLOT_CYCLES));
                        state_q   <= ST_JAM;
                    end else if (tx_done) begin
                        tx_ack  <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end

                ST_JAM: begin
                    if (jam_cnt_q == JAM_W'(JAM_CYCLES - 1)) begin
                        jam_en      <= 1'b0;
                        attempts_q  <= attempts_d;
                        retry_count <= bo_exponent(attempts_q);
                        if (late_q) begin
                            tx_abort     <= 1'b1;
                            abort_reason <= ABORT_LATE;
                            state_q      <= ST_ABORT;
                        end else if (attempts_d == ATT_W'(MAX_ATTEMPTS)) begin
                            tx_abort     <= 1'b1;
                            abort_reason <= ABORT_EXCESS;
                            state_q      <= ST_ABORT;
                        end else begin
                            backoff_init <= 1'b1;
                            state_q      <= ST_BO_START;
                        end
                    end else begin
                        jam_cnt_q <= jam_cnt_q + JAM_W'(1);
                    end
                end

                ST_BO_START: state_q <= ST_BO_WAIT;

                ST_BO_WAIT: begin
                    if (backoff_done) begin
                        state_q <= ST_DEFER;
                    end
                end

                ST_ACK: begin
                    attempts_q <= '0;
                    state_q    <= ST_IDLE;
                end

                ST_ABORT: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TX_STATS_EN
    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_total  <= '0;
            excess_cnt <= '0;
            late_cnt   <= '0;
        end else begin
            if (state_q == ST_TX && collision && col_total != 16'hFFFF) begin
                col_total <= col_total + 16'd1;
            end
            if (state_q == ST_ABORT && abort_reason == ABORT_EXCESS && excess_cnt != 16'hFFFF) begin
                excess_cnt <= excess_cnt + 16'd1;
            end
            if (state_q == ST_ABORT && abort_reason == ABORT_LATE && late_cnt != 16'hFFFF) begin
                late_cnt <= late_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_retry_ctrl.sv
// Directed self-checking bench for tx_retry_ctrl; stats checks are built when TX_STATS_EN is defined.
module tb_tx_retry_ctrl;

    logic       clock;
    logic       reset;
    logic       tx_req;
    logic       carrier_sense;
    logic       collision;
    logic       tx_done;
    logic       tx_start;
    logic       tx_stop;
    logic       jam_en;
    logic       backoff_init;
    logic [3:0] retry_count;
    logic       backoff_done;
    logic       tx_ack;
    logic       tx_abort;
    logic [1:0] abort_reason;
`ifdef TX_STATS_EN
    logic [15:0] col_total;
    logic [15:0] excess_cnt;
    logic [15:0] late_cnt;
`endif

    int checks = 0;
    int passed = 0;

    tx_retry_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .tx_req        (tx_req),
        .carrier_sense (carrier_sense),
        .collision     (collision),
        .tx_done       (tx_done),
        .tx_start      (tx_start),
        .tx_stop       (tx_stop),
        .jam_en        (jam_en),
        .backoff_init  (backoff_init),
        .retry_count   (retry_count),
        .backoff_done  (backoff_done),
        .tx_ack        (tx_ack),
        .tx_abort      (tx_abort),
`ifdef TX_STATS_EN
        .col_total     (col_total),
        .excess_cnt    (excess_cnt),
        .late_cnt      (late_cnt),
`endif
        .abort_reason  (abort_reason)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; outputs are then stable for the new cycle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Step until tx_start is seen or the budget runs out; n is cycles taken.
    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({tx_start, tx_stop, jam_en, backoff_init, tx_ack, tx_abort} !== 6'b0)
            $display("FAIL reset_pulses: got %b expected 000000",
                     {tx_start, tx_stop, jam_en, backoff_init, tx_ack, tx_abort});
        else passed++;
        checks++;
        if (retry_count !== 4'd0 || abort_reason !== 2'b00)
            $display("FAIL reset_fields: got retry=%0d reason=%b expected 0/00", retry_count, abort_reason);
        else passed++;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (tx_start !== 1'b0) $display("FAIL idle_no_start: got %b expected 0", tx_start);
        else passed++;
    endtask

    task automatic test_clean_send();
        int n;
        tx_req = 1'b1;
        step();
        wait_start(40, n);
        checks++;
        if (n !== 12) $display("FAIL clean_start_latency: got %0d expected 12", n);
        else passed++;
        repeat (99) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        checks++;
        if (tx_ack !== 1'b1) $display("FAIL clean_ack: got %b expected 1", tx_ack);
        else passed++;
        checks++;
        if (retry_count !== 4'd0) $display("FAIL clean_retry: got %0d expected 0", retry_count);
        else passed++;
        step();
        checks++;
        if (tx_ack !== 1'b0) $display("FAIL clean_ack_pulse: got %b expected 0", tx_ack);
        else passed++;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (tx_ack !== 1'b0 || tx_start !== 1'b0)
            $display("FAIL done_in_idle: got ack=%b start=%b expected 0/0", tx_ack, tx_start);
        else passed++;
    endtask

    task automatic test_defer();
        int n;
        int bad;
        tx_req = 1'b1;
        carrier_sense = 1'b1;
        step();
        bad = 0;
        repeat (50) begin
            if (tx_start !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) $display("FAIL defer_busy_start: got %0d starts expected 0", bad);
        else passed++;
        carrier_sense = 1'b0;
        wait_start(40, n);
        checks++;
        if (n !== 12) $display("FAIL defer_after_carrier: got %0d expected 12", n);
        else passed++;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        step();
        tx_req = 1'b1;
        step();
        repeat (11) step();
        carrier_sense = 1'b1;
        step();
        carrier_sense = 1'b0;
        checks++;
        if (tx_start !== 1'b0) $display("FAIL glitch_blocks_start: got %b expected 0", tx_start);
        else passed++;
        wait_start(40, n);
        checks++;
        if (n !== 12) $display("FAIL glitch_restart: got %0d expected 12", n);
        else passed++;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        checks++;
        if (tx_ack !== 1'b1) $display("FAIL glitch_ack: got %b expected 1", tx_ack);
        else passed++;
        step();
    endtask

    task automatic test_single_collision();
        int n;
        tx_req = 1'b1;
        step();
        wait_start(40, n);
        repeat (10) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        checks++;
        if (tx_stop !== 1'b1 || jam_en !== 1'b1)
            $display("FAIL col_stop_jam: got stop=%b jam=%b expected 1/1", tx_stop, jam_en);
        else passed++;
        n = 0;
        while (jam_en === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n !== 4) $display("FAIL col_jam_len: got %0d expected 4", n);
        else passed++;
        checks++;
        if (backoff_init !== 1'b1 || retry_count !== 4'd0)
            $display("FAIL col_bo_init: got init=%b retry=%0d expected 1/0", backoff_init, retry_count);
        else passed++;
        step();
        checks++;
        if (backoff_init !== 1'b0) $display("FAIL col_bo_pulse: got %b expected 0", backoff_init);
        else passed++;
        step();
        step();
        backoff_done = 1'b1;
        step();
        backoff_done = 1'b0;
        wait_start(40, n);
        checks++;
        if (n !== 12) $display("FAIL col_redefer: got %0d expected 12", n);
        else passed++;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        checks++;
        if (tx_ack !== 1'b1) $display("FAIL col_ack: got %b expected 1", tx_ack);
        else passed++;
        step();
    endtask

    task automatic test_excessive();
        int n;
        int exp_rc;
        tx_req = 1'b1;
        step();
        for (int a = 1; a <= 16; a++) begin
            wait_start(40, n);
            checks++;
            if (n !== 12) $display("FAIL exc_start a=%0d: got %0d expected 12", a, n);
            else passed++;
            collision = 1'b1;
            step();
            collision = 1'b0;
            repeat (4) step();
            exp_rc = (a - 1 > 9) ? 9 : a - 1;
            checks++;
            if (retry_count !== 4'(exp_rc))
                $display("FAIL exc_retry a=%0d: got %0d expected %0d", a, retry_count, exp_rc);
            else passed++;
            if (a < 16) begin
                checks++;
                if (backoff_init !== 1'b1 || tx_abort !== 1'b0)
                    $display("FAIL exc_bo a=%0d: got init=%b abort=%b expected 1/0", a, backoff_init, tx_abort);
                else passed++;
                step();
                backoff_done = 1'b1;
                step();
                backoff_done = 1'b0;
            end else begin
                checks++;
                if (tx_abort !== 1'b1 || abort_reason !== 2'b01 || backoff_init !== 1'b0)
                    $display("FAIL exc_abort: got abort=%b reason=%b init=%b expected 1/01/0",
                             tx_abort, abort_reason, backoff_init);
                else passed++;
                tx_req = 1'b0;
                step();
                checks++;
                if (tx_abort !== 1'b0 || abort_reason !== 2'b00)
                    $display("FAIL exc_abort_pulse: got abort=%b reason=%b expected 0/00", tx_abort, abort_reason);
                else passed++;
            end
        end
`ifdef TX_STATS_EN
        checks++;
        if (col_total !== 16'd17 || excess_cnt !== 16'd1)
            $display("FAIL stats_after_excess: got col=%0d exc=%0d expected 17/1", col_total, excess_cnt);
        else passed++;
`endif
    endtask

    task automatic test_late();
        int n;
        tx_req = 1'b1;
        step();
        wait_start(40, n);
        repeat (63) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        repeat (4) step();
        checks++;
        if (backoff_init !== 1'b1 || tx_abort !== 1'b0)
            $display("FAIL slot63_not_late: got init=%b abort=%b expected 1/0", backoff_init, tx_abort);
        else passed++;
        step();
        backoff_done = 1'b1;
        step();
        backoff_done = 1'b0;
        wait_start(40, n);
        repeat (64) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        checks++;
        if (tx_stop !== 1'b1) $display("FAIL late_stop: got %b expected 1", tx_stop);
        else passed++;
        n = 0;
        while (jam_en === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n !== 4) $display("FAIL late_jam_len: got %0d expected 4", n);
        else passed++;
        checks++;
        if (tx_abort !== 1'b1 || abort_reason !== 2'b10 || backoff_init !== 1'b0)
            $display("FAIL late_abort: got abort=%b reason=%b init=%b expected 1/10/0",
                     tx_abort, abort_reason, backoff_init);
        else passed++;
        checks++;
        if (retry_count !== 4'd1) $display("FAIL late_retry: got %0d expected 1", retry_count);
        else passed++;
        tx_req = 1'b0;
        step();
        checks++;
        if (tx_abort !== 1'b0 || abort_reason !== 2'b00)
            $display("FAIL late_abort_pulse: got abort=%b reason=%b expected 0/00", tx_abort, abort_reason);
        else passed++;
    endtask

    task automatic test_collision_vs_done();
        int n;
        tx_req = 1'b1;
        step();
        wait_start(40, n);
        repeat (5) step();
        collision = 1'b1;
        tx_done   = 1'b1;
        step();
        collision = 1'b0;
        tx_done   = 1'b0;
        checks++;
        if (tx_stop !== 1'b1 || jam_en !== 1'b1 || tx_ack !== 1'b0)
            $display("FAIL col_wins: got stop=%b jam=%b ack=%b expected 1/1/0", tx_stop, jam_en, tx_ack);
        else passed++;
        repeat (4) step();
        checks++;
        if (backoff_init !== 1'b1 || retry_count !== 4'd0)
            $display("FAIL col_wins_bo: got init=%b retry=%0d expected 1/0", backoff_init, retry_count);
        else passed++;
        step();
        backoff_done = 1'b1;
        step();
        backoff_done = 1'b0;
        wait_start(40, n);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        checks++;
        if (tx_ack !== 1'b1) $display("FAIL col_wins_ack: got %b expected 1", tx_ack);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid_jam();
        int n;
        int bad;
        tx_req = 1'b1;
        step();
        wait_start(40, n);
        repeat (2) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        step();
        checks++;
        if (jam_en !== 1'b1) $display("FAIL rst_jam_pre: got %b expected 1", jam_en);
        else passed++;
        reset  = 1'b1;
        tx_req = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if (jam_en !== 1'b0 || tx_abort !== 1'b0 || abort_reason !== 2'b00)
            $display("FAIL rst_jam_drop: got jam=%b abort=%b reason=%b expected 0/0/00",
                     jam_en, tx_abort, abort_reason);
        else passed++;
`ifdef TX_STATS_EN
        checks++;
        if (col_total !== 16'd0 || excess_cnt !== 16'd0 || late_cnt !== 16'd0)
            $display("FAIL rst_stats: got col=%0d exc=%0d late=%0d expected 0/0/0",
                     col_total, excess_cnt, late_cnt);
        else passed++;
`endif
        bad = 0;
        repeat (20) begin
            step();
            if (tx_start !== 1'b0 || tx_abort !== 1'b0 || jam_en !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL rst_idle_quiet: got %0d active cycles expected 0", bad);
        else passed++;
        tx_req = 1'b1;
        step();
        wait_start(40, n);
        checks++;
        if (n !== 12) $display("FAIL rst_fresh_start: got %0d expected 12", n);
        else passed++;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        checks++;
        if (tx_ack !== 1'b1) $display("FAIL rst_fresh_ack: got %b expected 1", tx_ack);
        else passed++;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        tx_req        = 1'b0;
        carrier_sense = 1'b0;
        collision     = 1'b0;
        tx_done       = 1'b0;
        backoff_done  = 1'b0;
        test_reset();
        test_clean_send();
        test_defer();
        test_single_collision();
        test_excessive();
        test_late();
        test_collision_vs_done();
        test_reset_mid_jam();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tx_retry_ctrl.md
Name: tx_retry_ctrl

Overview:
- Half-duplex CSMA/CD transmit sequencer for the MAC.
- Sits between the frame transmitter and the slot-time backoff generator.
- Owns deferral (carrier sense plus inter-packet gap), jam on collision, attempt counting, backoff launch, and excessive or late collision abort.
- Drives the backoff generator's init and retry_count inputs and consumes its trigger output as backoff_done.

Parameters:
MAX_ATTEMPTS, 16, transmission attempts before excessive-collision abort (2..16)
IPG_CYCLES, 12, carrier-free clocks required before starting a transmission
JAM_CYCLES, 4, clocks jam_en is held after a collision
SLOT_CYCLES, 64, clocks into TX after which a collision counts as late

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
tx_req  in  1  frame queued; held high until tx_ack or tx_abort
carrier_sense  in  1  medium busy
collision  in  1  PHY collision detect
tx_done  in  1  pulse: transmitter sent the last byte of the frame
tx_start  out  1  pulse: transmitter (re)starts the frame from the preamble
tx_stop  out  1  pulse: transmitter abandons the current frame
jam_en  out  1  transmitter drives the jam pattern
backoff_init  out  1  pulse to the backoff generator
retry_count  out  4  backoff exponent select for the generator
backoff_done  in  1  generator trigger; high means the backoff has expired
tx_ack  out  1  pulse: frame sent successfully
tx_abort  out  1  pulse: frame dropped
abort_reason  out  2  valid with tx_abort: 01 excessive, 10 late

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All counters are cleared.
  - All outputs go to 0.
  - Reset asserted mid-frame or mid-jam drops jam_en on the next edge; no tx_abort is issued.
- States: IDLE, DEFER, TX, JAM, BO_START, BO_WAIT, ACK, ABORT.
- IDLE: tx_req=1 → DEFER; the attempt counter is cleared.
- DEFER:
  - ipg_cnt clears on any cycle with carrier_sense=1 and increments otherwise.
  - When ipg_cnt==IPG_CYCLES-1 and carrier_sense=0: tx_start pulses for one cycle, slot_cnt clears, next state is TX.
  - Carrier rising on that same cycle blocks the start.
- TX:
  - slot_cnt increments and saturates at SLOT_CYCLES.
  - collision=1: tx_stop pulses, next state is JAM, and late_flag latches (slot_cnt>=SLOT_CYCLES).
  - tx_done=1 with collision=0: next state is ACK.
  - collision and tx_done in the same cycle: collision wins.
  - tx_done outside TX is ignored.
- JAM:
  - jam_en=1 for exactly JAM_CYCLES clocks.
  - On exit, the attempt counter increments (5-bit).
  - late_flag → ABORT with reason 10.
  - Otherwise, attempts==MAX_ATTEMPTS → ABORT with reason 01.
  - Otherwise → BO_START.
  - Collision input is ignored during JAM.
- BO_START:
  - backoff_init=1 for one cycle.
  - retry_count is registered as min(attempts-1, 9) and updated on JAM exit.
  - retry_count is stable from the BO_START cycle until the next JAM exit.
  - Next state is BO_WAIT.
- BO_WAIT: backoff_done=1 → DEFER. The generator clears its trigger on the edge that samples backoff_init, so backoff_done is valid from the first BO_WAIT cycle.
- ACK: tx_ack pulses for one cycle; the attempt counter clears; next state is IDLE.
- ABORT: tx_abort pulses for one cycle with abort_reason; next state is IDLE. abort_reason is 00 whenever tx_abort is 0.
- tx_req is sampled only in IDLE. Deassertion in any other state is ignored.
- Retries continue after collisions with no limit on waiting time, apart from attempt counting.

Optional Feature:
TX_STATS_EN
- Defined: adds three outputs, each 16 bits, saturating at 0xFFFF, cleared only by reset:
  - col_total: increments on every TX→JAM transition.
  - excess_cnt: increments on every reason-01 abort.
  - late_cnt: increments on every reason-10 abort.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package mac_tx_pkg holds:
  - the state enum;
  - the abort_reason encodings;
  - the defaults for IPG_CYCLES, JAM_CYCLES and SLOT_CYCLES;
  - the backoff exponent cap of 9.
- Sub-module tx_defer_timer encapsulates the IPG counter: inputs enable and carrier_sense, output gap_met pulse.

Test Plan:
1. Clean send: tx_req=1, carrier idle → tx_start at cycle 12 after DEFER entry; tx_done 100 cycles later → tx_ack 1 cycle after; retry_count unchanged.
2. Deferral: carrier_sense high for 50 cycles after tx_req → tx_start exactly 12 cycles after carrier falls; a carrier glitch at gap cycle 11 restarts the count.
3. Single collision: collision at TX cycle 10 → tx_stop, jam_en high 4 cycles, backoff_init with retry_count=0; backoff_done after 3 cycles → DEFER → tx_start → tx_done → tx_ack.
4. Excessive: collision on every attempt → retry_count sequence 0,1,...,9,9,...; 16th jam ends in tx_abort with abort_reason=01 and no 16th backoff_init.
5. Late collision: collision at TX cycle 70 → full 4-cycle jam, then tx_abort with reason=10 and no backoff_init; collision plus tx_done in the same cycle → JAM, not ACK.
6. Reset mid-jam: reset asserted on jam cycle 2 → jam_en=0 and state IDLE after the next edge; no tx_abort; with TX_STATS_EN, counters read 0.
